// File: rtl/trap_pkg.sv
// trap_pkg: shared types and default sizes for the trap EPC stack
package trap_pkg;
    localparam int XLEN_DEF  = 32;
    localparam int DEPTH_DEF = 4;
    typedef enum logic [1:0] {IDLE, NESTED, FULL} trap_state_e;
    typedef enum logic {CAUSE_IRQ, CAUSE_EXCEP} trap_cause_e;
endpackage

// File: rtl/trap_epc_stack_if.sv
// trap_epc_stack_if: trap request/return bus between the core and the EPC stack
// master drives trap sources, flushes and stage PCs; slave returns EPC, depth and status flags
interface trap_epc_stack_if
    import trap_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int DEPTH = DEPTH_DEF
) ();
    logic                       i_irq;
    logic                       i_irq_en;
    logic                       i_excep;
    logic                       i_mret;
    logic                       i_flush_id;
    logic                       i_flush_ex;
    logic [XLEN-1:0]            i_pc_if;
    logic [XLEN-1:0]            i_pc_id;
    logic [XLEN-1:0]            i_pc_ex;
    logic [XLEN-1:0]            o_epc;
    logic                       o_trap_take;
    logic                       o_cause_excep;
    logic [$clog2(DEPTH+1)-1:0] o_depth;
    logic                       o_overflow;
    logic                       o_underflow;
    modport master (
        output i_irq, i_irq_en, i_excep, i_mret, i_flush_id, i_flush_ex, i_pc_if, i_pc_id, i_pc_ex,
        input  o_epc, o_trap_take, o_cause_excep, o_depth, o_overflow, o_underflow
    );
    modport slave (
        input  i_irq, i_irq_en, i_excep, i_mret, i_flush_id, i_flush_ex, i_pc_if, i_pc_id, i_pc_ex,
        output o_epc, o_trap_take, o_cause_excep, o_depth, o_overflow, o_underflow
    );
endinterface

// File: rtl/trap_epc_lifo.sv
// trap_epc_lifo: saved-PC LIFO with push, pop and replace-top
// ports: i_clk, i_rst_n (async active-low), i_push/i_pop/i_replace (mutually exclusive),
//        i_data (value to write), o_top (top entry or 0 when empty), o_count (valid entries)
module trap_epc_lifo #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4,
    localparam int CW   = $clog2(DEPTH+1),
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_push,
    input  logic            i_pop,
    input  logic            i_replace,
    input  logic [XLEN-1:0] i_data,
    output logic [XLEN-1:0] o_top,
    output logic [CW-1:0]   o_count
);
    logic [XLEN-1:0] mem_q [DEPTH];
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   top_idx, wr_idx;
    always_comb begin
        top_idx = AW'(cnt_q - 1'b1);
        wr_idx  = i_push ? AW'(cnt_q) : top_idx;
        cnt_d   = i_push ? cnt_q + 1'b1 : i_pop ? cnt_q - 1'b1 : cnt_q;
        o_top   = (cnt_q == '0) ? '0 : mem_q[top_idx];
        o_count = cnt_q;
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (i_push || i_replace) mem_q[wr_idx] <= i_data;
        end
    end
endmodule

// File: rtl/trap_epc_stack.sv
// trap_epc_stack: nested trap return-PC stack with capture-PC selection and occupancy FSM
// ports: i_clk, i_rst_n (async active-low), bus (slave side of trap_epc_stack_if)
module trap_epc_stack
    import trap_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input logic             i_clk,
    input logic             i_rst_n,
    trap_epc_stack_if.slave bus
);
    localparam int CW = $clog2(DEPTH+1);
    trap_state_e     state_q, state_d;
    trap_cause_e     cause_q, cause_d;
    logic            flush_id_q, flush_id_qq, flush_ex_q;
    logic            trap_take_q, overflow_q, overflow_d, underflow_q;
    logic            irq_take, take, chain, push, pop, replace;
    logic [XLEN-1:0] cap_pc, top;
    logic [CW-1:0]   count;
    always_comb begin
        irq_take   = bus.i_irq && bus.i_irq_en && !bus.i_excep && state_q != FULL;
        take       = bus.i_excep || irq_take;
        // trap arriving with a return: reuse the slot being returned from
        chain      = take && bus.i_mret && state_q != IDLE;
        push       = take && !chain && state_q != FULL;
        // only an exception can reach here while full; it overwrites the top
        replace    = take && (chain || state_q == FULL);
        pop        = bus.i_mret && !take && state_q != IDLE;
        cap_pc     = (bus.i_excep || (!flush_id_q && !flush_ex_q)) ? bus.i_pc_if :
                     (!flush_ex_q || (!flush_id_qq && bus.i_irq)) ? bus.i_pc_id : bus.i_pc_ex;
        cause_d    = take ? (bus.i_excep ? CAUSE_EXCEP : CAUSE_IRQ) : cause_q;
        overflow_d = overflow_q || (bus.i_excep && state_q == FULL && !bus.i_mret);
        state_d    = state_q;
        case (state_q)
            IDLE:    state_d = push ? NESTED : IDLE;
            NESTED:  state_d = (push && count == CW'(DEPTH-1)) ? FULL :
                               (pop && count == CW'(1)) ? IDLE : NESTED;
            FULL:    state_d = pop ? NESTED : FULL;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            cause_q     <= CAUSE_IRQ;
            flush_id_q  <= 1'b0;
            flush_id_qq <= 1'b0;
            flush_ex_q  <= 1'b0;
            trap_take_q <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cause_q     <= cause_d;
            flush_id_q  <= bus.i_flush_id;
            flush_id_qq <= flush_id_q;
            flush_ex_q  <= bus.i_flush_ex;
            trap_take_q <= take;
            overflow_q  <= overflow_d;
            underflow_q <= bus.i_mret && !take && state_q == IDLE;
        end
    end
    trap_epc_lifo #(.XLEN(XLEN), .DEPTH(DEPTH)) u_lifo (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_push    (push),
        .i_pop     (pop),
        .i_replace (replace),
        .i_data    (cap_pc),
        .o_top     (top),
        .o_count   (count)
    );
    assign bus.o_epc         = top;
    assign bus.o_depth       = count;
    assign bus.o_trap_take   = trap_take_q;
    assign bus.o_cause_excep = cause_q == CAUSE_EXCEP;
    assign bus.o_overflow    = overflow_q;
    assign bus.o_underflow   = underflow_q;
endmodule

// File: tb/tb_trap_epc_stack.sv
// tb_trap_epc_stack: directed self-checking bench for trap_epc_stack
module tb_trap_epc_stack;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;
    trap_epc_stack_if #(.XLEN(32), .DEPTH(4)) bus ();
    trap_epc_stack #(.XLEN(32), .DEPTH(4)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic chk_state(input string tag, input logic [31:0] epc, input logic [31:0] depth);
        check({tag, "_epc"}, bus.o_epc, epc);
        check({tag, "_depth"}, 32'(bus.o_depth), depth);
    endtask
    task automatic quick_reset();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
    initial begin
        bus.i_irq = 0; bus.i_irq_en = 0; bus.i_excep = 0; bus.i_mret = 0;
        bus.i_flush_id = 0; bus.i_flush_ex = 0;
        bus.i_pc_if = 0; bus.i_pc_id = 0; bus.i_pc_ex = 0;
        step(); step();
        chk_state("rst", 0, 0);
        check("rst_take", 32'(bus.o_trap_take), 0);
        check("rst_cause", 32'(bus.o_cause_excep), 0);
        check("rst_ovf", 32'(bus.o_overflow), 0);
        check("rst_unf", 32'(bus.o_underflow), 0);
        rst_n = 1'b1;
        // exception with no flushes captures the IF PC
        bus.i_pc_if = 'h100; bus.i_excep = 1;
        step();
        bus.i_excep = 0;
        check("exc_take", 32'(bus.o_trap_take), 1);
        chk_state("exc", 'h100, 1);
        check("exc_cause", 32'(bus.o_cause_excep), 1);
        step();
        check("exc_take_pulse", 32'(bus.o_trap_take), 0);
        bus.i_mret = 1;
        step();
        bus.i_mret = 0;
        chk_state("exc_ret", 0, 0);
        // flush_ex held two cycles, irq in the second one
        bus.i_flush_ex = 1;
        step();
        bus.i_irq = 1; bus.i_irq_en = 1;
        bus.i_pc_if = 'h111; bus.i_pc_id = 'h200; bus.i_pc_ex = 'h200;
        step();
        bus.i_irq = 0; bus.i_flush_ex = 0;
        chk_state("fex", 'h200, 1);
        check("fex_cause", 32'(bus.o_cause_excep), 0);
        check("fex_take", 32'(bus.o_trap_take), 1);
        // flush_ex_q still set, flush_id_qq clear: ID PC chosen
        bus.i_irq = 1; bus.i_pc_id = 'h180; bus.i_pc_ex = 'h280;
        step();
        bus.i_irq = 0;
        chk_state("sel_id", 'h180, 2);
        // both flush histories set: EX PC chosen
        bus.i_flush_id = 1; bus.i_flush_ex = 1;
        step(); step();
        bus.i_irq = 1;
        step();
        bus.i_irq = 0; bus.i_flush_id = 0; bus.i_flush_ex = 0;
        chk_state("sel_ex", 'h280, 3);
        step(); step(); step();
        quick_reset();
        // fill to DEPTH via held irq
        bus.i_irq_en = 1; bus.i_irq = 1;
        bus.i_pc_if = 'h10; step(); chk_state("fill1", 'h10, 1);
        bus.i_pc_if = 'h20; step(); chk_state("fill2", 'h20, 2);
        bus.i_pc_if = 'h30; step(); chk_state("fill3", 'h30, 3);
        bus.i_pc_if = 'h40; step(); chk_state("fill4", 'h40, 4);
        bus.i_pc_if = 'h44; step();
        chk_state("full_irq", 'h40, 4);
        check("full_irq_take", 32'(bus.o_trap_take), 0);
        check("full_ovf0", 32'(bus.o_overflow), 0);
        bus.i_excep = 1; bus.i_pc_if = 'h50;
        step();
        bus.i_excep = 0; bus.i_irq = 0;
        chk_state("ovf", 'h50, 4);
        check("ovf_flag", 32'(bus.o_overflow), 1);
        check("ovf_take", 32'(bus.o_trap_take), 1);
        check("ovf_cause", 32'(bus.o_cause_excep), 1);
        bus.i_mret = 1;
        step();
        bus.i_mret = 0;
        chk_state("ovf_pop", 'h30, 3);
        check("ovf_sticky", 32'(bus.o_overflow), 1);
        // asynchronous reset mid-cycle at depth 3
        #3 rst_n = 1'b0;
        #1;
        chk_state("arst", 0, 0);
        check("arst_ovf", 32'(bus.o_overflow), 0);
        check("arst_take", 32'(bus.o_trap_take), 0);
        #1 rst_n = 1'b1;
        // pops down to empty, then underflow
        bus.i_irq = 1;
        bus.i_pc_if = 'h10; step();
        bus.i_pc_if = 'h20; step();
        bus.i_irq = 0;
        chk_state("pre_pop", 'h20, 2);
        bus.i_mret = 1;
        step(); chk_state("pop1", 'h10, 1);
        check("pop1_unf", 32'(bus.o_underflow), 0);
        step(); chk_state("pop2", 0, 0);
        step(); chk_state("pop3", 0, 0);
        check("unf", 32'(bus.o_underflow), 1);
        bus.i_mret = 0;
        step();
        check("unf_pulse", 32'(bus.o_underflow), 0);
        // tail-chain: return and exception together
        bus.i_irq = 1; bus.i_pc_if = 'h10;
        step();
        bus.i_irq = 0;
        bus.i_mret = 1; bus.i_excep = 1; bus.i_pc_if = 'h30;
        step();
        bus.i_mret = 0; bus.i_excep = 0;
        chk_state("chain", 'h30, 1);
        check("chain_take", 32'(bus.o_trap_take), 1);
        check("chain_unf", 32'(bus.o_underflow), 0);
        // simultaneous exception and irq: exception first, irq next cycle
        bus.i_excep = 1; bus.i_irq = 1; bus.i_pc_if = 'h60;
        step();
        bus.i_excep = 0; bus.i_pc_if = 'h70;
        chk_state("both", 'h60, 2);
        check("both_cause", 32'(bus.o_cause_excep), 1);
        step();
        bus.i_irq = 0;
        chk_state("defer", 'h70, 3);
        check("defer_cause", 32'(bus.o_cause_excep), 0);
        // irq blocked by enable
        bus.i_irq = 1; bus.i_irq_en = 0; bus.i_pc_if = 'h80;
        step();
        bus.i_irq = 0;
        chk_state("irq_off", 'h70, 3);
        check("irq_off_take", 32'(bus.o_trap_take), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
